devision_seq_param: RTL and testbench

Parametrised sequential integer divider: a WIDTH-bit dividend and divisor go in, a quotient and remainder come out, one quotient bit per clock using restoring division. It generalises the fixed 16-bit sequential divider with a width parameter, per-operation signed/unsigned mode, a busy indication and a defined divide-by-zero response. It sits between the operand registers and the seven-segment display path; its quotient feeds the LED encoder when WIDTH = 16.

---
 rtl/devision_seq_param.sv | 116 +++++++++++
 tb/tb_devision_seq_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/devision_seq_param.sv
// Restoring sequential divider: one quotient bit per clock, optional signed mode.
// Result after WIDTH+1 cycles (1 cycle for a zero divisor); start is ignored while busy.
module devision_seq_param #(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] dvd, dvs, a_lat;
  logic             q_neg, r_neg, zero;

  logic             mode, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH+1:0] shifted, diff;

  assign mode  = sign_mode & SIGNED_EN;
  assign a_neg = mode & a[WIDTH-1];
  assign b_neg = mode & b[WIDTH-1];
  // The most-negative value negates to itself, which is already its correct unsigned magnitude.
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign shifted = {prem, dvd[WIDTH-1]};
  assign diff    = shifted - {2'b00, dvs};
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (b == '0) ? FIX : CALC;
      CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      prem        <= '0;
      dvd         <= '0;
      dvs         <= '0;
      a_lat       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      zero        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      y           <= '0;
      remainder   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            prem  <= '0;
            dvd   <= a_mag;
            dvs   <= b_mag;
            a_lat <= a;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            zero  <= (b == '0);
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          // Negative trial difference means the divisor did not fit: keep the shifted value.
          if (!diff[WIDTH+1]) begin
            prem <= diff[WIDTH:0];
            dvd  <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            prem <= shifted[WIDTH:0];
            dvd  <= {dvd[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= zero;
          if (zero) begin
            y         <= '1;
            remainder <= a_lat;
          end else begin
            y         <= q_neg ? -dvd : dvd;
            remainder <= r_neg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_devision_seq_param.sv
// Scoreboard bench: drivers push expected results, per-instance monitors pop on done.
module tb_devision_seq_param;

  typedef struct {
    logic [15:0] y;
    logic [15:0] r;
    logic        z;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb16[$];
  exp_t        sb8[$];

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, dbz16;
  logic [15:0] y16, r16;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dbz8;
  logic [7:0]  y8, r8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  devision_seq_param #(.WIDTH(16), .SIGNED_EN(1'b1)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sign_mode(sm16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .div_by_zero(dbz16), .y(y16), .remainder(r16)
  );

  devision_seq_param #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sign_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_by_zero(dbz8), .y(y8), .remainder(r8)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Monitors: compare on every done, and flag any result that is overdue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done16) begin
        if (sb16.size() == 0) fail("spurious_done16");
        else begin
          e = sb16.pop_front();
          chk("y16", y16, e.y);
          chk("rem16", r16, e.r);
          chk("dbz16", dbz16, e.z);
          chk("lat16", cyc, e.due);
          chk("busy_in_done16", busy16, 0);
        end
      end else if (sb16.size() > 0 && cyc > sb16[0].due) begin
        fail("timeout16");
        void'(sb16.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done8) begin
        if (sb8.size() == 0) fail("spurious_done8");
        else begin
          e = sb8.pop_front();
          chk("y8", y8, e.y);
          chk("rem8", r8, e.r);
          chk("dbz8", dbz8, e.z);
          chk("lat8", cyc, e.due);
        end
      end else if (sb8.size() > 0 && cyc > sb8[0].due) begin
        fail("timeout8");
        void'(sb8.pop_front());
      end
    end
  end

  // Called at a negedge; start is sampled on the following posedge.
  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                         input logic [15:0] ey, input logic [15:0] er, input logic ez);
    exp_t e;
    e.y = ey; e.r = er; e.z = ez;
    e.due = cyc + ((b == 16'd0) ? 1 : 17) + 1;
    sb16.push_back(e);
    a16 = a; b16 = b; sm16 = sm; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    chk("busy_after_start16", busy16, 1);
  endtask

  task automatic wait16();
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done16) begin seen = 1; break; end
      @(negedge clk);
    end
    if (!seen) fail("wait16_timeout");
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input logic [7:0] ey, input logic [7:0] er);
    exp_t e;
    bit seen = 0;
    e.y = {8'h00, ey}; e.r = {8'h00, er}; e.z = 1'b0;
    e.due = cyc + 9 + 1;
    sb8.push_back(e);
    a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done8) begin seen = 1; break; end
      @(negedge clk);
    end
    if (!seen) fail("wait8_timeout");
  endtask

  task automatic model16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                         output logic [15:0] ey, output logic [15:0] er);
    int sa, sb;
    if (b == 16'd0) begin
      ey = 16'hFFFF; er = a;
    end else if (sm) begin
      sa = int'($signed(a)); sb = int'($signed(b));
      ey = 16'(sa / sb); er = 16'(sa % sb);
    end else begin
      ey = a / b; er = a % b;
    end
  endtask

  initial begin
    logic [15:0] ra, rb, ey, er;
    logic        rs;

    @(negedge clk);
    chk("rst_busy", busy16, 0);
    chk("rst_done", done16, 0);
    chk("rst_dbz", dbz16, 0);
    chk("rst_y", y16, 0);
    chk("rst_rem", r16, 0);
    rst = 1'b0;
    @(negedge clk);

    issue16(16'd110, 16'd25, 1'b0, 16'd4, 16'd10, 1'b0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (!busy16) fail("busy_dropped_early");
    end
    wait16();

    // Back-to-back: second start lands in the done cycle of the first.
    issue16(16'd32200, 16'd37, 1'b0, 16'd870, 16'd10, 1'b0);
    wait16();
    issue16(16'd1234, 16'd56, 1'b0, 16'd22, 16'd2, 1'b0);
    wait16();

    issue16(16'hFF92, 16'd25, 1'b1, 16'hFFFC, 16'hFFF6, 1'b0);
    wait16();
    issue16(16'd110, 16'hFFE7, 1'b1, 16'hFFFC, 16'd10, 1'b0);
    wait16();
    issue16(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'd0, 1'b0);
    wait16();
    issue16(16'hFF92, 16'd25, 1'b0, 16'd2617, 16'd1, 1'b0);
    wait16();

    issue16(16'd1234, 16'd0, 1'b0, 16'hFFFF, 16'd1234, 1'b1);
    wait16();
    issue16(16'd110, 16'd25, 1'b0, 16'd4, 16'd10, 1'b0);
    wait16();

    // A start while busy must be dropped; only one done may follow.
    issue16(16'd110, 16'd25, 1'b0, 16'd4, 16'd10, 1'b0);
    repeat (5) @(negedge clk);
    a16 = 16'd50; b16 = 16'd7; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    wait16();
    repeat (20) @(negedge clk);

    // Reset mid-operation clears outputs at once and suppresses done.
    issue16(16'd32200, 16'd37, 1'b0, 16'd870, 16'd10, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    sb16.delete();
    #1;
    chk("midrst_busy", busy16, 0);
    chk("midrst_done", done16, 0);
    chk("midrst_y", y16, 0);
    chk("midrst_rem", r16, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    run8(8'd200, 8'd7, 1'b1, 8'd28, 8'd4);
    run8(8'hFF, 8'h10, 1'b1, 8'd15, 8'd15);
    run8(8'd9, 8'd10, 1'b0, 8'd0, 8'd9);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = (i % 50 == 0) ? 16'd0 : 16'($urandom_range(0, 3) == 0 ? $urandom_range(1, 15) : $urandom);
      rs = 1'($urandom);
      model16(ra, rb, rs, ey, er);
      issue16(ra, rb, rs, ey, er, rb == 16'd0);
      wait16();
    end
    repeat (20) @(negedge clk);
    if (sb16.size() != 0 || sb8.size() != 0) fail("scoreboard_not_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
